// File: rtl/parking_gate_ctrl_pkg.sv
// Shared types and defaults for the parking gate controller.
// Gate state names, parameter defaults, gate_abort bit positions and a saturating counter helper.
package parking_gate_pkg;

  typedef enum logic [2:0] {
    G_IDLE,
    G_CHECK,
    G_OPEN,
    G_PEND,
    G_CLOSE,
    G_DENY
  } gate_state_t;

  localparam int DEBOUNCE_DEF     = 4;
  localparam int OPEN_TIMEOUT_DEF = 64;
  localparam int CLOSE_HOLD_DEF   = 8;

  localparam int ABORT_ENTRY = 0;
  localparam int ABORT_EXIT  = 1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Sensor, badge, vacancy and event signals between the gate controller and its surroundings.
// The controller takes the slave side; the environment driving sensors takes the master side.
interface parking_gate_ctrl_if;
  logic       entry_sensor;
  logic       entry_badge_uni;
  logic       exit_sensor;
  logic       exit_badge_uni;
  logic       uni_is_vacated_space;
  logic       is_vacated_space;
  logic       car_entered;
  logic       is_uni_car_entered;
  logic       car_exited;
  logic       is_uni_car_exited;
  logic       entry_barrier_up;
  logic       exit_barrier_up;
  logic       entry_denied;
  logic [1:0] gate_abort;

  modport master (
    output entry_sensor, entry_badge_uni, exit_sensor, exit_badge_uni,
           uni_is_vacated_space, is_vacated_space,
    input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
           entry_barrier_up, exit_barrier_up, entry_denied, gate_abort
  );

  modport slave (
    input  entry_sensor, entry_badge_uni, exit_sensor, exit_badge_uni,
           uni_is_vacated_space, is_vacated_space,
    output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
           entry_barrier_up, exit_barrier_up, entry_denied, gate_abort
  );
endinterface

// File: rtl/parking_gate_ctrl_gate_fsm.sv
// One barrier gate: loop debouncer, admission check, barrier timer and close hold.
// Barrier rises DEBOUNCE+1 cycles after a raw sensor rise; sits in PEND until the arbiter grants.
module gate_fsm
  import parking_gate_pkg::*;
#(
  parameter bit IS_ENTRY     = 1'b1,
  parameter int DEBOUNCE     = DEBOUNCE_DEF,
  parameter int OPEN_TIMEOUT = OPEN_TIMEOUT_DEF,
  parameter int CLOSE_HOLD   = CLOSE_HOLD_DEF
) (
  input  logic        clk,
  input  logic        start,
  input  logic        sensor,
  input  logic        badge_uni,
  input  logic        uni_vac,
  input  logic        gen_vac,
  input  logic        grant,
  output gate_state_t state,
  output logic        barrier_up,
  output logic        abort,
  output logic        uni
);

  logic       filt;
  logic [3:0] db_cnt;
  logic       db_flip;
  logic       lvl;
  logic       admit;
  logic [7:0] timer;

  // lvl is the filtered level as it will be after this edge, so the FSM reacts in the flip cycle
  assign db_flip = (sensor != filt) && (db_cnt == 4'(DEBOUNCE - 1));
  assign lvl     = db_flip ? sensor : filt;
  assign admit   = !IS_ENTRY || (badge_uni ? uni_vac : gen_vac);

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      filt   <= 1'b0;
      db_cnt <= '0;
    end else if (sensor == filt) begin
      db_cnt <= '0;
    end else if (db_flip) begin
      filt   <= sensor;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state      <= G_IDLE;
      barrier_up <= 1'b0;
      abort      <= 1'b0;
      uni        <= 1'b0;
      timer      <= '0;
    end else begin
      abort <= 1'b0;
      case (state)
        G_IDLE: if (lvl) state <= G_CHECK;
        G_CHECK: begin
          uni <= badge_uni;
          if (admit) begin
            state      <= G_OPEN;
            barrier_up <= 1'b1;
            timer      <= '0;
          end else begin
            state <= G_DENY;
          end
        end
        G_OPEN: begin
          if (!lvl) begin
            state      <= G_PEND;
            barrier_up <= 1'b0;
          end else if (timer == 8'(OPEN_TIMEOUT - 1)) begin
            state      <= G_CLOSE;
            barrier_up <= 1'b0;
            abort      <= 1'b1;
            timer      <= '0;
          end else begin
            timer <= sat_inc(timer);
          end
        end
        G_PEND: begin
          if (grant) begin
            state <= G_CLOSE;
            timer <= '0;
          end
        end
        G_CLOSE: begin
          if (timer == 8'(CLOSE_HOLD - 1)) state <= G_IDLE;
          else                              timer <= sat_inc(timer);
        end
        G_DENY: if (!lvl) state <= G_IDLE;
        default: state <= G_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit gate pair plus the event arbiter feeding the occupancy tracker.
// Events are registered; exit wins ties and every event is followed by one idle cycle.
module parking_gate_ctrl
  import parking_gate_pkg::*;
#(
  parameter int DEBOUNCE     = DEBOUNCE_DEF,
  parameter int OPEN_TIMEOUT = OPEN_TIMEOUT_DEF,
  parameter int CLOSE_HOLD   = CLOSE_HOLD_DEF
) (
  input logic                clk,
  input logic                start,
  parking_gate_ctrl_if.slave bus
);

  gate_state_t ent_state, ext_state;
  logic ent_barrier, ext_barrier;
  logic ent_abort, ext_abort;
  logic ent_uni, ext_uni;
  logic ent_grant, ext_grant;
  logic ent_pend, ext_pend, gap;
  logic ce_q, uce_q, cx_q, ucx_q;

  gate_fsm #(
    .IS_ENTRY(1'b1), .DEBOUNCE(DEBOUNCE),
    .OPEN_TIMEOUT(OPEN_TIMEOUT), .CLOSE_HOLD(CLOSE_HOLD)
  ) u_entry (
    .clk(clk), .start(start),
    .sensor(bus.entry_sensor), .badge_uni(bus.entry_badge_uni),
    .uni_vac(bus.uni_is_vacated_space), .gen_vac(bus.is_vacated_space),
    .grant(ent_grant), .state(ent_state), .barrier_up(ent_barrier),
    .abort(ent_abort), .uni(ent_uni)
  );

  gate_fsm #(
    .IS_ENTRY(1'b0), .DEBOUNCE(DEBOUNCE),
    .OPEN_TIMEOUT(OPEN_TIMEOUT), .CLOSE_HOLD(CLOSE_HOLD)
  ) u_exit (
    .clk(clk), .start(start),
    .sensor(bus.exit_sensor), .badge_uni(bus.exit_badge_uni),
    .uni_vac(bus.uni_is_vacated_space), .gen_vac(bus.is_vacated_space),
    .grant(ext_grant), .state(ext_state), .barrier_up(ext_barrier),
    .abort(ext_abort), .uni(ext_uni)
  );

  // The tracker is edge-sensitive and ignores exit while entered is high
  assign ent_pend  = (ent_state == G_PEND);
  assign ext_pend  = (ext_state == G_PEND);
  assign gap       = ce_q | cx_q;
  assign ext_grant = ext_pend && !gap;
  assign ent_grant = ent_pend && !ext_pend && !gap;

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      ce_q  <= 1'b0;
      uce_q <= 1'b0;
      cx_q  <= 1'b0;
      ucx_q <= 1'b0;
    end else begin
      ce_q  <= ent_grant;
      uce_q <= ent_grant & ent_uni;
      cx_q  <= ext_grant;
      ucx_q <= ext_grant & ext_uni;
    end
  end

  assign bus.car_entered              = ce_q;
  assign bus.is_uni_car_entered       = uce_q;
  assign bus.car_exited               = cx_q;
  assign bus.is_uni_car_exited        = ucx_q;
  assign bus.entry_barrier_up         = ent_barrier;
  assign bus.exit_barrier_up          = ext_barrier;
  assign bus.entry_denied             = (ent_state == G_DENY);
  assign bus.gate_abort[ABORT_ENTRY]  = ent_abort;
  assign bus.gate_abort[ABORT_EXIT]   = ext_abort;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed scenarios for parking_gate_ctrl, checked every cycle against a timestamp-based gate model.
module tb_parking_gate_ctrl;
  localparam int D = 4, T = 64, H = 8;
  localparam int M_IDLE = 0, M_CHECK = 1, M_OPEN = 2, M_PEND = 3, M_CLOSE = 4, M_DENY = 5;

  logic clk = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  parking_gate_ctrl_if pif();
  parking_gate_ctrl #(.DEBOUNCE(D), .OPEN_TIMEOUT(T), .CLOSE_HOLD(H)) dut (
    .clk(clk), .start(start), .bus(pif)
  );

  int errors = 0, checks = 0;
  int mode [2];
  int t_mark [2];
  int run [2];
  bit lvl [2], last [2], cls [2];
  int cyc = 0;
  bit e_ce, e_uce, e_cx, e_ucx;
  bit [1:0] e_ab;

  int ncyc = 0, n_ce = 0, n_cx = 0, n_ab0 = 0, n_eb = 0, n_den = 0;
  int ce_cyc = 0, cx_cyc = 0;
  bit ce_uni, cx_uni;

  function automatic logic [8:0] outs();
    return {pif.car_entered, pif.is_uni_car_entered, pif.car_exited, pif.is_uni_car_exited,
            pif.entry_barrier_up, pif.exit_barrier_up, pif.entry_denied, pif.gate_abort};
  endfunction

  function automatic logic [8:0] expect_outs();
    return {e_ce, e_uce, e_cx, e_ucx, mode[0] == M_OPEN, mode[1] == M_OPEN,
            mode[0] == M_DENY, e_ab};
  endfunction

  // Gate model: run-length filter on raw samples, timestamps for timeouts and hold periods
  always @(posedge clk or negedge start) begin : model
    bit raw [2];
    bit gr [2];
    bit gap, ok;
    if (!start) begin
      for (int g = 0; g < 2; g++) begin
        mode[g] = M_IDLE; lvl[g] = 0; last[g] = 0; run[g] = 0; cls[g] = 0; t_mark[g] = 0;
      end
      e_ce = 0; e_uce = 0; e_cx = 0; e_ucx = 0; e_ab = 0;
    end else begin
      cyc++;
      raw[0] = pif.entry_sensor;
      raw[1] = pif.exit_sensor;
      for (int g = 0; g < 2; g++) begin
        run[g] = (raw[g] == last[g]) ? run[g] + 1 : 1;
        last[g] = raw[g];
        if (raw[g] != lvl[g] && run[g] >= D) lvl[g] = raw[g];
      end
      gap = e_ce | e_cx;
      gr[1] = (mode[1] == M_PEND) && !gap;
      gr[0] = (mode[0] == M_PEND) && (mode[1] != M_PEND) && !gap;
      e_cx = gr[1]; e_ucx = gr[1] && cls[1];
      e_ce = gr[0]; e_uce = gr[0] && cls[0];
      e_ab = 0;
      for (int g = 0; g < 2; g++) begin
        case (mode[g])
          M_IDLE: if (lvl[g]) mode[g] = M_CHECK;
          M_CHECK: begin
            cls[g] = (g == 0) ? pif.entry_badge_uni : pif.exit_badge_uni;
            ok = (g == 1) || (cls[g] ? pif.uni_is_vacated_space : pif.is_vacated_space);
            mode[g] = ok ? M_OPEN : M_DENY;
            t_mark[g] = cyc;
          end
          M_OPEN: begin
            if (!lvl[g]) mode[g] = M_PEND;
            else if (cyc == t_mark[g] + T) begin
              mode[g] = M_CLOSE; e_ab[g] = 1'b1; t_mark[g] = cyc;
            end
          end
          M_PEND: if (gr[g]) begin mode[g] = M_CLOSE; t_mark[g] = cyc; end
          M_CLOSE: if (cyc == t_mark[g] + H) mode[g] = M_IDLE;
          M_DENY: if (!lvl[g]) mode[g] = M_IDLE;
          default: mode[g] = M_IDLE;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    ncyc++;
    checks++;
    if (outs() !== expect_outs()) begin
      errors++;
      $display("FAIL cycle_cmp cyc=%0d got=%b want=%b", ncyc, outs(), expect_outs());
    end
    if (pif.car_entered) begin n_ce++; ce_cyc = ncyc; ce_uni = pif.is_uni_car_entered; end
    if (pif.car_exited)  begin n_cx++; cx_cyc = ncyc; cx_uni = pif.is_uni_car_exited;  end
    if (pif.gate_abort[0])    n_ab0++;
    if (pif.entry_barrier_up) n_eb++;
    if (pif.entry_denied)     n_den++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  int b_ce, b_cx, b_ab, b_eb, b_den;

  task automatic snap();
    b_ce = n_ce; b_cx = n_cx; b_ab = n_ab0; b_eb = n_eb; b_den = n_den;
  endtask

  initial begin
    pif.entry_sensor = 0; pif.entry_badge_uni = 0; pif.exit_sensor = 0; pif.exit_badge_uni = 0;
    pif.uni_is_vacated_space = 0; pif.is_vacated_space = 0;

    // Reset held while sensors toggle
    for (int i = 0; i < 8; i++) begin
      tick(1);
      pif.entry_sensor = ~pif.entry_sensor;
      pif.exit_sensor  = (i % 3) == 0;
    end
    tick(1);
    chk("reset_outs", 32'(outs()), 0);
    pif.entry_sensor = 0; pif.exit_sensor = 0;
    tick(2);
    start = 1;
    tick(2);

    // Uni car admitted through the uni flag only
    snap();
    pif.entry_badge_uni = 1; pif.uni_is_vacated_space = 1; pif.is_vacated_space = 0;
    pif.entry_sensor = 1;
    tick(D);
    chk("s1_barrier_wait", 32'(pif.entry_barrier_up), 0);
    tick(1);
    chk("s1_barrier_rise", 32'(pif.entry_barrier_up), 1);
    tick(20 - (D + 1));
    pif.entry_sensor = 0;
    tick(30);
    chk("s1_one_entry", n_ce - b_ce, 1);
    chk("s1_uni_class", 32'(ce_uni), 1);

    // General car refused
    snap();
    pif.entry_badge_uni = 0; pif.is_vacated_space = 0;
    pif.entry_sensor = 1;
    tick(D);
    chk("s2_not_yet_denied", 32'(pif.entry_denied), 0);
    tick(1);
    chk("s2_denied", 32'(pif.entry_denied), 1);
    tick(8);
    pif.entry_sensor = 0;
    tick(D - 1);
    chk("s2_deny_hold", 32'(pif.entry_denied), 1);
    tick(1);
    chk("s2_deny_release", 32'(pif.entry_denied), 0);
    tick(12);
    chk("s2_no_entry", n_ce - b_ce, 0);
    chk("s2_no_barrier", n_eb - b_eb, 0);

    // Both gates reach PEND together
    snap();
    pif.is_vacated_space = 1; pif.entry_badge_uni = 0; pif.exit_badge_uni = 1;
    pif.entry_sensor = 1; pif.exit_sensor = 1;
    tick(10);
    pif.entry_sensor = 0; pif.exit_sensor = 0;
    tick(30);
    chk("s3_one_entry", n_ce - b_ce, 1);
    chk("s3_one_exit", n_cx - b_cx, 1);
    chk("s3_spacing", ce_cyc - cx_cyc, 2);
    chk("s3_exit_uni", 32'(cx_uni), 1);
    chk("s3_entry_general", 32'(ce_uni), 0);
    pif.exit_badge_uni = 0;

    // Loop held past the open timeout; re-check is refused
    snap();
    pif.entry_sensor = 1;
    tick(70);
    pif.is_vacated_space = 0;
    tick(30);
    pif.entry_sensor = 0;
    tick(D + 12);
    chk("s4_abort_once", n_ab0 - b_ab, 1);
    chk("s4_barrier_cycles", n_eb - b_eb, T);
    chk("s4_no_entry", n_ce - b_ce, 0);
    chk("s4_recheck_denied", n_den - b_den, 25);

    // Reset asserted with exit barrier up and entry event pending
    pif.is_vacated_space = 1;
    pif.exit_sensor = 1; pif.entry_sensor = 1;
    tick(10);
    pif.entry_sensor = 0;
    tick(D);
    chk("s5_exit_up", 32'(pif.exit_barrier_up), 1);
    snap();
    start = 0;
    #1;
    chk("s5_async_clear", 32'(outs()), 0);
    pif.entry_sensor = 0; pif.exit_sensor = 0;
    tick(3);
    start = 1;
    tick(30);
    chk("s5_no_entry", n_ce - b_ce, 0);
    chk("s5_no_exit", n_cx - b_cx, 0);

    // Three general cars; space runs out after the second
    snap();
    pif.is_vacated_space = 1; pif.entry_badge_uni = 0;
    for (int k = 0; k < 3; k++) begin
      pif.entry_sensor = 1;
      tick(8);
      pif.entry_sensor = 0;
      tick(D + 2);
      if (k == 1) pif.is_vacated_space = 0;
      tick(H + 4);
    end
    chk("s6_two_entries", n_ce - b_ce, 2);
    chk("s6_third_denied", n_den - b_den, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
